// File: rtl/regfile_np.sv
// Multi-port register file with a self-clearing sequence after reset or on request.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_np #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     busy
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                busy_q;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_zero;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign busy    = busy_q;

  // State register; busy is registered from the next state so it tracks CLEAR exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= (state_d == CLEAR);
    end
  end

  // Next state and the single storage write port (clear sweep or user write).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    case (state_q)
      CLEAR: begin
        if (clr_req) begin
          clr_cnt_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = '0;
          clr_cnt_d = ADDR_W'(clr_cnt_q + 1'b1);
          if (clr_cnt_q == LAST_ADDR) state_d = READY;
        end
      end
      READY: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (we && !wr_zero) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Storage has no reset of its own; a pending write is dropped when rst is high.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      val = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (!busy_q && we && !clr_req && !wr_zero && (addr == wr_addr)) val = wr_data;
`endif
      if (busy_q || ((ZERO_REG != 0) && (addr == '0))) val = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_np.sv
// Self-checking bench for regfile_np: constant-vector table, directed clear/reset
// sequences and randomized traffic checked against an array-based reference model.
module tb_regfile_np;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_req;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             busy;

  always #5 clk = ~clk;

  regfile_np #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr_req(clr_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy)
  );

  int nerr = 0;
  int nchk = 0;

  // Reference model: cycles of clearing left, and the architectural register contents.
  int            clear_left = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r0;
    logic [AW-1:0] r1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (clear_left > 0 || a == '0) return '0;
    if (BYP && we && !clr_req && a == wr_addr) return wr_data;
    return ref_mem[a];
  endfunction

  task automatic model_step();
    if (rst || clr_req) begin
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (we && wr_addr != '0) begin
      ref_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, " busy"}, DW'(busy), DW'(clear_left > 0));
    chk({tag, " rd0"}, rd_data[DW-1:0], exp_rd(rd_addr[AW-1:0]));
    chk({tag, " rd1"}, rd_data[2*DW-1:DW], exp_rd(rd_addr[2*AW-1:AW]));
  endtask

  task automatic count_busy(input string tag, input int expn);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      check_model(tag);
      edge_step();
      n++;
    end
    chk({tag, " busy cycles"}, DW'(n), DW'(expn));
  endtask

  task automatic read_const(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
    set_rd(a, a);
    #1;
    chk({tag, " p0"}, rd_data[DW-1:0], e);
    chk({tag, " p1"}, rd_data[2*DW-1:DW], e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd8, 32'd200,       5'd8, 5'd8, BYP ? 32'd200 : 32'd0, BYP ? 32'd200 : 32'd0};
    tbl[1] = '{1'b0, 5'd0, 32'd0,         5'd8, 5'd8, 32'd200, 32'd200};
    tbl[2] = '{1'b1, 5'd0, 32'd5,         5'd0, 5'd8, 32'd0, 32'd200};
    tbl[3] = '{1'b0, 5'd0, 32'd0,         5'd0, 5'd0, 32'd0, 32'd0};
    tbl[4] = '{1'b1, 5'd9, 32'hDEADBEEF,  5'd9, 5'd8, BYP ? 32'hDEADBEEF : 32'd0, 32'd200};
    tbl[5] = '{1'b0, 5'd0, 32'd0,         5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 5'd9, 32'd1234,      5'd9, 5'd1, BYP ? 32'd1234 : 32'hDEADBEEF, 32'd0};
    tbl[7] = '{1'b0, 5'd0, 32'd0,         5'd9, 5'd8, 32'd1234, 32'd200};

    foreach (ref_mem[i]) ref_mem[i] = '0;
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; set_rd(5'd0, 5'd0);

    // Reset for two cycles, then a full clear; writes during the clear are ignored.
    edge_step();
    edge_step();
    rst = 1'b0; we = 1'b1; wr_addr = 5'd7; wr_data = 32'd123; set_rd(5'd7, 5'd3);
    count_busy("reset", 32);
    we = 1'b0;
    chk("ready busy", DW'(busy), 32'd0);
    read_const("r7 after clear", 5'd7, 32'd0);

    // Constant vector table: write/read, zero register, same-cycle read of written address.
    for (int i = 0; i < 8; i++) begin
      we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      set_rd(tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d p0", i), rd_data[DW-1:0], tbl[i].e0);
      chk($sformatf("tbl%0d p1", i), rd_data[2*DW-1:DW], tbl[i].e1);
      edge_step();
    end
    we = 1'b0;

    // Fill r1..r31 with their index, then sweep both ports with wrap to 0.
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wr_addr = AW'(a); wr_data = DW'(a);
      set_rd(AW'($urandom), AW'(a));
      check_model("fill");
      edge_step();
    end
    we = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      set_rd(AW'(k % 32), AW'((k + 1) % 32));
      #1;
      chk($sformatf("sweep%0d p0", k), rd_data[DW-1:0], DW'(k % 32));
      chk($sformatf("sweep%0d p1", k), rd_data[2*DW-1:DW], DW'((k + 1) % 32));
      edge_step();
    end
    read_const("r0 after wrap", 5'd0, 32'd0);
    read_const("r1 after wrap", 5'd1, 32'd1);
    read_const("r31 after wrap", 5'd31, 32'd31);

    // clr_req together with a write to r3, then restart the clear at cycle 10.
    clr_req = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'd99; set_rd(5'd3, 5'd5);
    check_model("clr start");
    edge_step();
    clr_req = 1'b0; we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_model("clr early");
      edge_step();
    end
    clr_req = 1'b1;
    check_model("clr restart");
    edge_step();
    clr_req = 1'b0;
    count_busy("clr restart", 32);
    read_const("r3 after clear", 5'd3, 32'd0);
    read_const("r5 after clear", 5'd5, 32'd0);

    // rst mid-clear while a write of 77 to r4 is presented.
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'd55;
    edge_step();
    we = 1'b0; clr_req = 1'b1;
    edge_step();
    clr_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_model("pre rst");
      edge_step();
    end
    rst = 1'b1; we = 1'b1; wr_addr = 5'd4; wr_data = 32'd77;
    edge_step();
    rst = 1'b0; we = 1'b0; set_rd(5'd4, 5'd4);
    count_busy("rst midclear", 32);
    read_const("r4 after rst midclear", 5'd4, 32'd0);

    // rst in READY during a write of 77 to r4: write dropped.
    rst = 1'b1; we = 1'b1; wr_addr = 5'd4; wr_data = 32'd77;
    edge_step();
    rst = 1'b0; we = 1'b0;
    count_busy("rst midwrite", 32);
    read_const("r4 after rst midwrite", 5'd4, 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clr_req = ($urandom_range(0, 49) == 0);
      we      = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      set_rd(AW'($urandom), ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom));
      check_model("rand");
      edge_step();
    end
    rst = 1'b0; clr_req = 1'b0; we = 1'b0;
    check_model("rand end");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
